irq_trap_ctrl: RTL and testbench
================================

IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

Interface
REQ-001 SHALL have parameter TRAP_VEC, default 32'h0001_0000, trap handler entry address.
REQ-002 SHALL have parameter CAUSE_EXT, default 32'h8000_000B, mcause for external IRQ.
REQ-003 SHALL have parameter CAUSE_DMA, default 32'h8000_0010, mcause for DMA/EPU IRQ.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port irq_ext  in  1  external interrupt, level.
REQ-007 SHALL have port irq_dma  in  1  DMA/EPU done, single-cycle pulse.
REQ-008 SHALL have port mstatus_mie  in  1  global interrupt enable from CSR file.
REQ-009 SHALL have port mie_meie  in  1  machine external enable from CSR file.
REQ-010 SHALL have port wfi  in  1  WFI in EX stage.
REQ-011 SHALL have port mret  in  1  MRET in EX stage.
REQ-012 SHALL have port pipe_stall  in  1  hazard or memory stall active.
REQ-013 SHALL have port ex_pc  in  32  PC of EX-stage instruction.
REQ-014 SHALL have port trap_ack  in  1  CSR file has committed trap-entry update.
REQ-015 SHALL have port trap_req  out  1  trap-entry request to CSR file.
REQ-016 SHALL have port trap_epc  out  32  PC to save into mepc.
REQ-017 SHALL have port trap_cause  out  32  value for mcause.
REQ-018 SHALL have port redirect  out  1  one-cycle pipeline flush and PC redirect.
REQ-019 SHALL have port redirect_pc  out  32  redirect target.
REQ-020 SHALL have port halt  out  1  freeze fetch while sleeping.

Function
REQ-021 SHALL latch irq_dma into pend_dma on the pulse and clear it only in the cycle trap_ack is sampled for a DMA trap.
REQ-022 SHALL form take = mstatus_mie & mie_meie & (irq_ext | pend_dma), with priority ext > dma > timer.
REQ-023 SHALL implement FSM states RUN, SLEEP, TRAP, RET.
REQ-024 RUN: take & !pipe_stall -> TRAP; capture trap_epc = ex_pc and trap_cause of the winning source.
REQ-025 RUN: mret & !pipe_stall & !take -> RET; wfi & !pipe_stall & !take -> SLEEP; take wins over both.
REQ-026 SLEEP: halt = 1; (irq_ext | pend_dma) pending, even with mstatus_mie = 0, -> RUN with halt = 0 next cycle; enabled pending -> TRAP with trap_epc = ex_pc + 4.
REQ-027 TRAP: trap_req held at 1 with trap_epc/trap_cause stable until trap_ack; on trap_ack -> RUN, redirect = 1 for one cycle, redirect_pc = TRAP_VEC.
REQ-028 RET: redirect = 1 for one cycle, redirect_pc = mepc-sourced address; the block outputs trap_epc of the last trap, then -> RUN.
REQ-029 A source dropping while in TRAP SHALL NOT cancel the request; the latched cause is kept.
REQ-030 No new trap SHALL be taken in the cycle redirect is high.
REQ-031 Address arithmetic SHALL be 32-bit modulo; ex_pc + 4 wraps at 2^32.

Reset
REQ-032 On rst: state = RUN, pend_dma = 0, trap_req = 0, redirect = 0, halt = 0, trap_epc = 0, trap_cause = 0, redirect_pc = 0.
REQ-033 rst mid-TRAP or mid-SLEEP SHALL abort immediately with no redirect.

Configuration
REQ-034 SHALL support macro IRQ_MTIMER_EN.
REQ-035 With IRQ_MTIMER_EN defined: adds ports tmr_we (in, 1), tmr_wdata (in, 64) and mie_mtie (in, 1).
  - Adds a 64-bit mtime counter incrementing every clk.
  - tmr_we loads mtimecmp.
  - Timer pending = mtime >= mtimecmp, gated by mie_mtie, cause 32'h8000_0007, lowest priority.
REQ-036 Without IRQ_MTIMER_EN: no timer ports and no timer logic; behaviour is identical to REQ-021..031.

Verification
REQ-037 irq_ext = 1, both enables = 1, ex_pc = 0x100, no stall -> trap_req next cycle, trap_epc = 0x100, trap_cause = 0x8000000B.
REQ-038 irq_dma pulse with mstatus_mie = 0, then enable 5 cycles later -> trap taken with cause 0x80000010; pend_dma clears on trap_ack.
REQ-039 wfi with ex_pc = 0x200 -> halt = 1; irq_ext asserted -> trap_epc = 0x204; trap_ack -> redirect = 1, redirect_pc = 0x00010000.
REQ-040 irq_ext together with mret in the same cycle -> trap wins; RET is not entered.
REQ-041 pipe_stall = 1 for 3 cycles with irq_ext pending -> trap_req rises only after the stall drops.
REQ-042 rst asserted while trap_req = 1 -> all outputs 0 immediately; state returns to RUN.

Source files
------------

// File: rtl/irq_trap_ctrl.sv
// Interrupt/trap sequencer: takes external and DMA interrupts, sequences trap entry, MRET and WFI sleep.
// Optional machine timer (mtime/mtimecmp) is built only when IRQ_MTIMER_EN is defined.
module irq_trap_ctrl #(
   parameter logic [31:0] TRAP_VEC  = 32'h0001_0000,
   parameter logic [31:0] CAUSE_EXT = 32'h8000_000B,
   parameter logic [31:0] CAUSE_DMA = 32'h8000_0010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        irq_ext,
   input  logic        irq_dma,
   input  logic        mstatus_mie,
   input  logic        mie_meie,
   input  logic        wfi,
   input  logic        mret,
   input  logic        pipe_stall,
   input  logic [31:0] ex_pc,
   input  logic        trap_ack,
`ifdef IRQ_MTIMER_EN
   input  logic        tmr_we,
   input  logic [63:0] tmr_wdata,
   input  logic        mie_mtie,
`endif
   output logic        trap_req,
   output logic [31:0] trap_epc,
   output logic [31:0] trap_cause,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        halt,
   output logic [1:0]  dbg_state_o
);

   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

   // Handshake: trap_req rises with trap_epc/trap_cause valid and all three stay
   // stable until the cycle trap_ack is sampled high; the request then drops.
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_SLEEP = 2'd1,
      S_TRAP  = 2'd2,
      S_RET   = 2'd3
   } state_e;

   state_e      state_q;
   logic        trap_req_q;
   logic [31:0] trap_epc_q;
   logic [31:0] trap_cause_q;
   logic        redirect_q;
   logic [31:0] redirect_pc_q;
   logic        halt_q;
   logic        trap_dma_q;
   logic        pend_dma_q;
   logic        pend_dma_d;

   logic        tmr_pend;
   logic        ext_take;
   logic        dma_take;
   logic        tmr_take;
   logic        take;
   logic        src_pend;
   logic [31:0] cause_sel;

`ifdef IRQ_MTIMER_EN
   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;

   // mtimecmp resets to all-ones so the timer stays quiet until software programs it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
      end else begin
         mtime_q <= mtime_q + 64'd1;
         if (tmr_we) begin
            mtimecmp_q <= tmr_wdata;
         end
      end
   end

   assign tmr_pend = mie_mtie & (mtime_q >= mtimecmp_q);
`else
   assign tmr_pend = 1'b0;
`endif

   always_comb begin
      ext_take = mstatus_mie & mie_meie & irq_ext;
      dma_take = mstatus_mie & mie_meie & pend_dma_q;
      tmr_take = mstatus_mie & tmr_pend;
      take     = ext_take | dma_take | tmr_take;
      src_pend = irq_ext | pend_dma_q | tmr_pend;
      if (ext_take) begin
         cause_sel = CAUSE_EXT;
      end else if (dma_take) begin
         cause_sel = CAUSE_DMA;
      end else begin
         cause_sel = CAUSE_TMR;
      end
   end

   // A fresh pulse wins over a clear landing in the same cycle.
   always_comb begin
      pend_dma_d = pend_dma_q;
      if (state_q == S_TRAP && trap_ack && trap_dma_q) begin
         pend_dma_d = 1'b0;
      end
      if (irq_dma) begin
         pend_dma_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_dma_q <= 1'b0;
      end else begin
         pend_dma_q <= pend_dma_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_RUN;
         trap_req_q    <= 1'b0;
         trap_epc_q    <= '0;
         trap_cause_q  <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         halt_q        <= 1'b0;
         trap_dma_q    <= 1'b0;
      end else begin
         redirect_q <= 1'b0;
         case (state_q)
            S_RUN: begin
               // The EX instruction is being flushed while redirect is high.
               if (!pipe_stall && !redirect_q) begin
                  if (take) begin
                     state_q      <= S_TRAP;
                     trap_req_q   <= 1'b1;
                     trap_epc_q   <= ex_pc;
                     trap_cause_q <= cause_sel;
                     trap_dma_q   <= !ext_take && dma_take;
                  end else if (mret) begin
                     state_q       <= S_RET;
                     redirect_q    <= 1'b1;
                     redirect_pc_q <= trap_epc_q;
                  end else if (wfi) begin
                     state_q <= S_SLEEP;
                     halt_q  <= 1'b1;
                  end
               end
            end
            S_SLEEP: begin
               if (take) begin
                  state_q      <= S_TRAP;
                  halt_q       <= 1'b0;
                  trap_req_q   <= 1'b1;
                  trap_epc_q   <= ex_pc + 32'd4;
                  trap_cause_q <= cause_sel;
                  trap_dma_q   <= !ext_take && dma_take;
               end else if (src_pend) begin
                  state_q <= S_RUN;
                  halt_q  <= 1'b0;
               end
            end
            S_TRAP: begin
               if (trap_ack) begin
                  state_q       <= S_RUN;
                  trap_req_q    <= 1'b0;
                  redirect_q    <= 1'b1;
                  redirect_pc_q <= TRAP_VEC;
               end
            end
            S_RET: begin
               state_q <= S_RUN;
            end
            default: begin
               state_q <= S_RUN;
            end
         endcase
      end
   end

   assign trap_req    = trap_req_q;
   assign trap_epc    = trap_epc_q;
   assign trap_cause  = trap_cause_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign halt        = halt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Table-driven bench for irq_trap_ctrl (default build, IRQ_MTIMER_EN undefined) with a
// scoreboard queue and hand-written asynchronous-reset sequences.
module tb_irq_trap_ctrl;

   localparam logic [1:0]  RUN = 2'd0;
   localparam logic [1:0]  SLP = 2'd1;
   localparam logic [1:0]  TRP = 2'd2;
   localparam logic [1:0]  RET = 2'd3;
   localparam logic [31:0] CE  = 32'h8000_000B;
   localparam logic [31:0] CD  = 32'h8000_0010;
   localparam logic [31:0] TV  = 32'h0001_0000;

   // control word bit order: {rst, ext, dma, mie, meie, wfi, mret, stall, ack}
   localparam logic [8:0] C_RST  = 9'b1_0000_0000;
   localparam logic [8:0] C_EXT  = 9'b0_1000_0000;
   localparam logic [8:0] C_DMA  = 9'b0_0100_0000;
   localparam logic [8:0] C_MIE  = 9'b0_0010_0000;
   localparam logic [8:0] C_MEIE = 9'b0_0001_0000;
   localparam logic [8:0] C_WFI  = 9'b0_0000_1000;
   localparam logic [8:0] C_MRET = 9'b0_0000_0100;
   localparam logic [8:0] C_STL  = 9'b0_0000_0010;
   localparam logic [8:0] C_ACK  = 9'b0_0000_0001;
   localparam logic [8:0] C_EN   = C_MIE | C_MEIE;
   localparam logic [8:0] C_IDLE = 9'b0_0000_0000;

   typedef struct packed {
      logic        req;
      logic [31:0] epc;
      logic [31:0] cause;
      logic        redir;
      logic [31:0] rpc;
      logic        halt;
      logic [1:0]  st;
   } out_t;

   typedef struct {
      string       name;
      logic [8:0]  ctl;
      logic [31:0] pc;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, irq_ext, irq_dma, mstatus_mie, mie_meie, wfi, mret, pipe_stall, trap_ack;
   logic [31:0] ex_pc;
   logic        trap_req, redirect, halt;
   logic [31:0] trap_epc, trap_cause, redirect_pc;
   logic [1:0]  dbg_state_o;

   vec_t         vecs[$];
   logic [100:0] exp_q[$];
   string        name_q[$];
   int           n_vec = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   irq_trap_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .irq_ext     (irq_ext),
      .irq_dma     (irq_dma),
      .mstatus_mie (mstatus_mie),
      .mie_meie    (mie_meie),
      .wfi         (wfi),
      .mret        (mret),
      .pipe_stall  (pipe_stall),
      .ex_pc       (ex_pc),
      .trap_ack    (trap_ack),
      .trap_req    (trap_req),
      .trap_epc    (trap_epc),
      .trap_cause  (trap_cause),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .dbg_state_o (dbg_state_o)
   );

   function automatic vec_t mkv(input string n, input logic [8:0] c, input logic [31:0] pc,
                                input logic rq, input logic [31:0] epc, input logic [31:0] cause,
                                input logic rd, input logic [31:0] rpc, input logic h,
                                input logic [1:0] st);
      vec_t v;
      v.name = n;
      v.ctl  = c;
      v.pc   = pc;
      v.exp  = {rq, epc, cause, rd, rpc, h, st};
      return v;
   endfunction

   function automatic void add(input string n, input logic [8:0] c, input logic [31:0] pc,
                               input logic rq, input logic [31:0] epc, input logic [31:0] cause,
                               input logic rd, input logic [31:0] rpc, input logic h,
                               input logic [1:0] st);
      vecs.push_back(mkv(n, c, pc, rq, epc, cause, rd, rpc, h, st));
   endfunction

   task automatic drive(input logic [8:0] c, input logic [31:0] pc);
      {rst, irq_ext, irq_dma, mstatus_mie, mie_meie, wfi, mret, pipe_stall, trap_ack} = c;
      ex_pc = pc;
   endtask

   task automatic compare();
      out_t  e;
      out_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {trap_req, trap_epc, trap_cause, redirect, redirect_pc, halt, dbg_state_o};
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got req=%b epc=%h cause=%h redir=%b rpc=%h halt=%b st=%0d, want req=%b epc=%h cause=%h redir=%b rpc=%h halt=%b st=%0d",
                  n, a.req, a.epc, a.cause, a.redir, a.rpc, a.halt, a.st,
                  e.req, e.epc, e.cause, e.redir, e.rpc, e.halt, e.st);
      end
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      drive(v.ctl, v.pc);
      exp_q.push_back(v.exp);
      name_q.push_back(v.name);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic check_now(input string n, input out_t e);
      exp_q.push_back(e);
      name_q.push_back(n);
      compare();
   endtask

   task automatic async_reset_check(input string n);
      #2;
      rst = 1'b1;
      #1;
      check_now(n, '0);
   endtask

   initial begin
      drive(C_RST, 32'h0);

      //   name            ctl                    pc            req epc           cause rd rpc           h  st
      add("reset",        C_RST,                 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,       0, RUN);
      add("idle",         C_IDLE,                32'h0,        0, 32'h0,        32'h0, 0, 32'h0,       0, RUN);
      add("ext_take",     C_EXT | C_EN,          32'h100,      1, 32'h100,      CE,    0, 32'h0,       0, TRP);
      add("ext_drop",     C_EN,                  32'h104,      1, 32'h100,      CE,    0, 32'h0,       0, TRP);
      add("ext_ack",      C_EN | C_ACK,          32'h104,      0, 32'h100,      CE,    1, TV,          0, RUN);
      add("redir_block",  C_EXT | C_EN,          32'h104,      0, 32'h100,      CE,    0, TV,          0, RUN);
      add("ext_take2",    C_EXT | C_EN,          32'h108,      1, 32'h108,      CE,    0, TV,          0, TRP);
      add("ack2",         C_ACK,                 32'h108,      0, 32'h108,      CE,    1, TV,          0, RUN);
      add("idle2",        C_IDLE,                32'h10c,      0, 32'h108,      CE,    0, TV,          0, RUN);
      add("ext_vs_mret",  C_EXT | C_EN | C_MRET, 32'h200,      1, 32'h200,      CE,    0, TV,          0, TRP);
      add("ack3",         C_ACK,                 32'h200,      0, 32'h200,      CE,    1, TV,          0, RUN);
      add("idle3",        C_IDLE,                32'h204,      0, 32'h200,      CE,    0, TV,          0, RUN);
      add("mret",         C_MRET,                32'h300,      0, 32'h200,      CE,    1, 32'h200,     0, RET);
      add("ret_done",     C_IDLE,                32'h304,      0, 32'h200,      CE,    0, 32'h200,     0, RUN);
      for (int i = 0; i < 3; i++)
         add("stall_hold", C_EXT | C_EN | C_STL, 32'h400,      0, 32'h200,      CE,    0, 32'h200,     0, RUN);
      add("stall_drop",   C_EXT | C_EN,          32'h400,      1, 32'h400,      CE,    0, 32'h200,     0, TRP);
      add("ack4",         C_ACK,                 32'h404,      0, 32'h400,      CE,    1, TV,          0, RUN);
      add("idle4",        C_IDLE,                32'h408,      0, 32'h400,      CE,    0, TV,          0, RUN);
      add("dma_masked",   C_DMA | C_MEIE,        32'h500,      0, 32'h400,      CE,    0, TV,          0, RUN);
      for (int i = 0; i < 4; i++)
         add("dma_wait",  C_MEIE,                32'h500,      0, 32'h400,      CE,    0, TV,          0, RUN);
      add("dma_enable",   C_EN,                  32'h504,      1, 32'h504,      CD,    0, TV,          0, TRP);
      add("dma_ack",      C_EN | C_ACK,          32'h504,      0, 32'h504,      CD,    1, TV,          0, RUN);
      add("dma_redir",    C_EN,                  32'h508,      0, 32'h504,      CD,    0, TV,          0, RUN);
      add("dma_cleared",  C_EN,                  32'h508,      0, 32'h504,      CD,    0, TV,          0, RUN);
      add("dma_meie_off", C_DMA | C_MIE,         32'h600,      0, 32'h504,      CD,    0, TV,          0, RUN);
      add("ext_over_dma", C_EXT | C_EN,          32'h600,      1, 32'h600,      CE,    0, TV,          0, TRP);
      add("ack5",         C_ACK,                 32'h604,      0, 32'h600,      CE,    1, TV,          0, RUN);
      add("redir5",       C_EN,                  32'h604,      0, 32'h600,      CE,    0, TV,          0, RUN);
      add("dma_after",    C_EN,                  32'h608,      1, 32'h608,      CD,    0, TV,          0, TRP);
      add("ack6",         C_ACK,                 32'h608,      0, 32'h608,      CD,    1, TV,          0, RUN);
      add("idle6",        C_IDLE,                32'h60c,      0, 32'h608,      CD,    0, TV,          0, RUN);
      add("wfi",          C_WFI | C_EN,          32'h200,      0, 32'h608,      CD,    0, TV,          1, SLP);
      add("sleep_hold",   C_EN,                  32'h200,      0, 32'h608,      CD,    0, TV,          1, SLP);
      add("wake_trap",    C_EXT | C_EN,          32'h200,      1, 32'h204,      CE,    0, TV,          0, TRP);
      add("ack7",         C_ACK,                 32'h200,      0, 32'h204,      CE,    1, TV,          0, RUN);
      add("idle7",        C_IDLE,                32'h200,      0, 32'h204,      CE,    0, TV,          0, RUN);
      add("wfi_mie0",     C_WFI | C_MEIE,        32'h700,      0, 32'h204,      CE,    0, TV,          1, SLP);
      add("wake_no_trap", C_EXT | C_MEIE,        32'h700,      0, 32'h204,      CE,    0, TV,          0, RUN);
      add("idle8",        C_IDLE,                32'h704,      0, 32'h204,      CE,    0, TV,          0, RUN);
      add("wfi_top",      C_WFI | C_EN,          32'hFFFF_FFFC, 0, 32'h204,     CE,    0, TV,          1, SLP);
      add("dma_in_sleep", C_DMA | C_EN,          32'hFFFF_FFFC, 0, 32'h204,     CE,    0, TV,          1, SLP);
      add("wrap_epc",     C_EN,                  32'hFFFF_FFFC, 1, 32'h0,       CD,    0, TV,          0, TRP);
      add("ack8",         C_ACK,                 32'hFFFF_FFFC, 0, 32'h0,       CD,    1, TV,          0, RUN);
      add("idle9",        C_IDLE,                32'h0,        0, 32'h0,        CD,    0, TV,          0, RUN);
      add("wfi_stall",    C_WFI | C_EN | C_STL,  32'h10,       0, 32'h0,        CD,    0, TV,          0, RUN);
      add("idle10",       C_IDLE,                32'h14,       0, 32'h0,        CD,    0, TV,          0, RUN);

      foreach (vecs[i]) step(vecs[i]);

      // async reset while a trap request is outstanding
      step(mkv("pre_rst_trap", C_EXT | C_EN, 32'h800, 1, 32'h800, CE, 0, TV, 0, TRP));
      async_reset_check("rst_mid_trap");
      step(mkv("rst_hold_a", C_RST, 32'h800, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));
      step(mkv("no_redir_a", C_IDLE, 32'h804, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));

      // async reset while sleeping
      step(mkv("pre_rst_slp", C_WFI | C_EN, 32'h900, 0, 32'h0, 32'h0, 0, 32'h0, 1, SLP));
      async_reset_check("rst_mid_sleep");
      step(mkv("rst_hold_b", C_RST, 32'h900, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));
      step(mkv("no_redir_b", C_IDLE, 32'h904, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));

      // reset discards a latched DMA pulse
      step(mkv("dma_pre_rst", C_DMA | C_MEIE, 32'ha00, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));
      async_reset_check("rst_pend");
      step(mkv("rst_hold_c", C_RST, 32'ha00, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));
      step(mkv("pend_gone", C_EN, 32'ha04, 0, 32'h0, 32'h0, 0, 32'h0, 0, RUN));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
